// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its environment: I-cache request/response,
// redirect/exception controls, decode stall and the registered instruction output.
interface fetch_stage_if #(
    parameter int unsigned ARCH_BITS = 32
);
    logic                 icReq;
    logic [ARCH_BITS-1:0] icAddr;
    logic                 icRespValid;
    logic [ARCH_BITS-1:0] icRespData;
    logic                 redirectValid;
    logic [ARCH_BITS-1:0] redirectPc;
    logic                 exceptValid;
    logic                 stall;
    logic                 outValid;
    logic [ARCH_BITS-1:0] outInst;
    logic [ARCH_BITS-1:0] outPc;

    modport master (
        output icReq,
        output icAddr,
        input  icRespValid,
        input  icRespData,
        input  redirectValid,
        input  redirectPc,
        input  exceptValid,
        input  stall,
        output outValid,
        output outInst,
        output outPc
    );

    modport slave (
        input  icReq,
        input  icAddr,
        output icRespValid,
        output icRespData,
        output redirectValid,
        output redirectPc,
        output exceptValid,
        output stall,
        input  outValid,
        input  outInst,
        input  outPc
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding I-cache request, a registered output to decode
// with a one-entry hold buffer for stalls, and redirect/exception steering of the PC.
module fetch_stage #(
    parameter int unsigned          ARCH_BITS = 32,
    parameter logic [ARCH_BITS-1:0] PC_RST    = 32'h0000_1000,
    parameter logic [ARCH_BITS-1:0] PC_EXCEPT = 32'h0000_2000
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StDrain
    } state_e;

    state_e               state_q, state_d;
    logic [ARCH_BITS-1:0] pc_q, pc_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [ARCH_BITS-1:0] hold_inst_q, hold_inst_d;
    logic [ARCH_BITS-1:0] hold_pc_q, hold_pc_d;
    logic                 out_valid_q, out_valid_d;
    logic [ARCH_BITS-1:0] out_inst_q, out_inst_d;
    logic [ARCH_BITS-1:0] out_pc_q, out_pc_d;

    logic                 redirect;
    logic [ARCH_BITS-1:0] redirect_target;
    logic [ARCH_BITS-1:0] pc_inc;
    logic                 issue;

    assign redirect        = bus.redirectValid | bus.exceptValid;
    assign redirect_target = bus.exceptValid ? PC_EXCEPT
                                             : {bus.redirectPc[ARCH_BITS-1:2], 2'b00};
    assign pc_inc          = pc_q + ARCH_BITS'(4);

    // Request is combinational so a latency-k cache sustains one fetch every k+1 cycles;
    // gating with rst keeps the strobe low for the whole reset window.
    assign issue = rst & (state_q == StFetch) & ~hold_valid_q & ~redirect;

    assign bus.icReq    = issue;
    assign bus.icAddr   = issue ? pc_q : '0;
    assign bus.outValid = out_valid_q;
    assign bus.outInst  = out_inst_q;
    assign bus.outPc    = out_pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_valid_d = hold_valid_q;
        hold_inst_d  = hold_inst_q;
        hold_pc_d    = hold_pc_q;
        out_valid_d  = out_valid_q;
        out_inst_d   = out_inst_q;
        out_pc_d     = out_pc_q;

        if (out_valid_q && !bus.stall) begin
            out_valid_d = 1'b0;
        end
        // A held word only exists behind a valid output, so it refills the slot just freed.
        if (hold_valid_q && !bus.stall) begin
            out_valid_d  = 1'b1;
            out_inst_d   = hold_inst_q;
            out_pc_d     = hold_pc_q;
            hold_valid_d = 1'b0;
        end

        case (state_q)
            StFetch: begin
                if (redirect) begin
                    pc_d = redirect_target;
                end else if (!hold_valid_q) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    state_d = bus.icRespValid ? StFetch : StDrain;
                end else if (bus.icRespValid) begin
                    if (out_valid_q && bus.stall) begin
                        hold_valid_d = 1'b1;
                        hold_inst_d  = bus.icRespData;
                        hold_pc_d    = pc_q;
                    end else begin
                        out_valid_d = 1'b1;
                        out_inst_d  = bus.icRespData;
                        out_pc_d    = pc_q;
                    end
                    pc_d    = pc_inc;
                    state_d = StFetch;
                end
            end
            StDrain: begin
                // The stale response is still owed by the cache; swallow it before refetching.
                if (redirect) begin
                    pc_d = redirect_target;
                end
                if (bus.icRespValid) begin
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        if (redirect) begin
            out_valid_d  = 1'b0;
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StFetch;
            pc_q         <= PC_RST;
            hold_valid_q <= 1'b0;
            hold_inst_q  <= '0;
            hold_pc_q    <= '0;
            out_valid_q  <= 1'b0;
            out_inst_q   <= '0;
            out_pc_q     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_valid_q <= hold_valid_d;
            hold_inst_q  <= hold_inst_d;
            hold_pc_q    <= hold_pc_d;
            out_valid_q  <= out_valid_d;
            out_inst_q   <= out_inst_d;
            out_pc_q     <= out_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written multi-cycle sequences and a
// randomized run against a transaction-level model of the fetch stream.
`timescale 1ns/1ps
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if #(.ARCH_BITS(32)) bus ();

    fetch_stage #(
        .ARCH_BITS(32),
        .PC_RST   (32'h0000_1000),
        .PC_EXCEPT(32'h0000_2000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        st;
        logic        resp;
        logic [31:0] data;
        logic        rdv;
        logic [31:0] rpc;
        logic        ex;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t v(logic st, logic resp, logic [31:0] data, logic rdv,
                               logic [31:0] rpc, logic ex, logic e_req, logic [31:0] e_addr,
                               logic e_ov, logic [31:0] e_pc, logic [31:0] e_inst);
        vec_t r;
        r.st = st; r.resp = resp; r.data = data; r.rdv = rdv; r.rpc = rpc; r.ex = ex;
        r.e_req = e_req; r.e_addr = e_addr; r.e_ov = e_ov; r.e_pc = e_pc; r.e_inst = e_inst;
        return r;
    endfunction

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic drive(input logic st, input logic resp, input logic [31:0] data,
                         input logic rdv, input logic [31:0] rpc, input logic ex);
        bus.stall         = st;
        bus.icRespValid   = resp;
        bus.icRespData    = data;
        bus.redirectValid = rdv;
        bus.redirectPc    = rpc;
        bus.exceptValid   = ex;
    endtask

    // Called at a negedge: drive, sample mid-low-phase, then advance to the next negedge.
    task automatic cyc(input string name, input vec_t t);
        drive(t.st, t.resp, t.data, t.rdv, t.rpc, t.ex);
        #2;
        check({name, " icReq"}, 32'(bus.icReq), 32'(t.e_req));
        if (t.e_req) check({name, " icAddr"}, bus.icAddr, t.e_addr);
        check({name, " outValid"}, 32'(bus.outValid), 32'(t.e_ov));
        if (t.e_ov) begin
            check({name, " outPc"}, bus.outPc, t.e_pc);
            check({name, " outInst"}, bus.outInst, t.e_inst);
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input string name);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        check({name, " icReq"}, 32'(bus.icReq), 32'h0);
        check({name, " icAddr"}, bus.icAddr, 32'h0);
        check({name, " outValid"}, 32'(bus.outValid), 32'h0);
        check({name, " outInst"}, bus.outInst, 32'h0);
        check({name, " outPc"}, bus.outPc, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Model: queue of delivered-but-unconsumed words, one outstanding cache request which a
    // redirect kills, and the next fetch address.
    task automatic run_random(input int n);
        logic [31:0] q_pc[$];
        logic [31:0] q_inst[$];
        logic        outstanding = 1'b0;
        logic        killed = 1'b0;
        logic [31:0] req_addr = 32'h0;
        logic [31:0] mpc = 32'h0000_1000;
        int          due = 0;
        for (int c = 0; c < n; c++) begin
            logic st, ex, rdv, resp, redir, e_req;
            logic [31:0] rpc, data;
            st    = ($urandom_range(0, 99) < 30);
            ex    = ($urandom_range(0, 99) < 2);
            rdv   = ($urandom_range(0, 99) < 5);
            rpc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom;
            resp  = outstanding && (c == due);
            if (!outstanding && $urandom_range(0, 99) < 5) resp = 1'b1;
            data  = (resp && outstanding) ? inst_of(req_addr) : $urandom;
            drive(st, resp, data, rdv, rpc, ex);
            #2;
            redir = rdv | ex;
            e_req = !outstanding && (q_pc.size() < 2) && !redir;
            check("rnd icReq", 32'(bus.icReq), 32'(e_req));
            if (e_req) check("rnd icAddr", bus.icAddr, mpc);
            check("rnd outValid", 32'(bus.outValid), 32'(q_pc.size() != 0));
            if (q_pc.size() != 0) begin
                check("rnd outPc", bus.outPc, q_pc[0]);
                check("rnd outInst", bus.outInst, q_inst[0]);
            end
            if (redir) begin
                q_pc.delete();
                q_inst.delete();
                mpc = ex ? 32'h0000_2000 : {rpc[31:2], 2'b00};
                if (outstanding) begin
                    if (resp) begin
                        outstanding = 1'b0;
                        killed = 1'b0;
                    end else begin
                        killed = 1'b1;
                    end
                end
            end else begin
                if (q_pc.size() != 0 && !st) begin
                    void'(q_pc.pop_front());
                    void'(q_inst.pop_front());
                end
                if (outstanding && resp) begin
                    if (!killed) begin
                        q_pc.push_back(req_addr);
                        q_inst.push_back(data);
                        mpc = req_addr + 32'd4;
                    end
                    outstanding = 1'b0;
                    killed = 1'b0;
                end
            end
            if (e_req) begin
                outstanding = 1'b1;
                killed = 1'b0;
                req_addr = mpc;
                due = c + int'($urandom_range(1, 4));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        // Latency-1 stream, exception beating redirect, redirect to the top of memory.
        tbl[0]  = v(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_1000, 0, 0, 0);
        tbl[1]  = v(0, 1, 32'hC0DE_0000, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0);
        tbl[2]  = v(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_1004,
                    1, 32'h0000_1000, 32'hC0DE_0000);
        tbl[3]  = v(0, 1, 32'hC0DE_0001, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0);
        tbl[4]  = v(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_1008,
                    1, 32'h0000_1004, 32'hC0DE_0001);
        tbl[5]  = v(0, 1, 32'hC0DE_0002, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0);
        tbl[6]  = v(0, 0, 32'h0,         1, 32'h0000_4000, 1, 0, 32'h0,
                    1, 32'h0000_1008, 32'hC0DE_0002);
        tbl[7]  = v(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_2000, 0, 0, 0);
        tbl[8]  = v(0, 1, 32'hC0DE_0003, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0);
        tbl[9]  = v(0, 0, 32'h0,         1, 32'hFFFF_FFFE, 0, 0, 32'h0,
                    1, 32'h0000_2000, 32'hC0DE_0003);
        tbl[10] = v(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        tbl[11] = v(0, 1, 32'hC0DE_0004, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0);
        tbl[12] = v(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0000,
                    1, 32'hFFFF_FFFC, 32'hC0DE_0004);
        tbl[13] = v(0, 1, 32'hC0DE_0005, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0);
        tbl[14] = v(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0004,
                    1, 32'h0000_0000, 32'hC0DE_0005);

        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        do_reset("reset0");
        for (int i = 0; i < 15; i++) cyc($sformatf("t%0d", i), tbl[i]);

        // Stall held five cycles while a response arrives into the hold buffer.
        do_reset("reset1");
        cyc("s0",  v(0, 0, 32'h0,      0, 0, 0, 1, 32'h1000, 0, 0, 0));
        cyc("s1",  v(0, 1, 32'hA0,     0, 0, 0, 0, 0,        0, 0, 0));
        cyc("s2",  v(1, 0, 32'h0,      0, 0, 0, 1, 32'h1004, 1, 32'h1000, 32'hA0));
        cyc("s3",  v(1, 1, 32'hA1,     0, 0, 0, 0, 0,        1, 32'h1000, 32'hA0));
        cyc("s4",  v(1, 0, 32'h0,      0, 0, 0, 0, 0,        1, 32'h1000, 32'hA0));
        cyc("s5",  v(1, 0, 32'h0,      0, 0, 0, 0, 0,        1, 32'h1000, 32'hA0));
        cyc("s6",  v(1, 0, 32'h0,      0, 0, 0, 0, 0,        1, 32'h1000, 32'hA0));
        cyc("s7",  v(0, 0, 32'h0,      0, 0, 0, 0, 0,        1, 32'h1000, 32'hA0));
        cyc("s8",  v(0, 0, 32'h0,      0, 0, 0, 1, 32'h1008, 1, 32'h1004, 32'hA1));
        cyc("s9",  v(0, 1, 32'hA2,     0, 0, 0, 0, 0,        0, 0, 0));
        cyc("s10", v(0, 0, 32'h0,      0, 0, 0, 1, 32'h100C, 1, 32'h1008, 32'hA2));
        cyc("s11", v(1, 1, 32'hA3,     0, 0, 0, 0, 0,        0, 0, 0));
        do_reset("reset2");

        // Redirect while waiting on a latency-3 response, then redirects inside DRAIN.
        cyc("d0",  v(0, 0, 32'h0,      0, 0,         0, 1, 32'h1000, 0, 0, 0));
        cyc("d1",  v(0, 0, 32'h0,      1, 32'h3006,  0, 0, 0,        0, 0, 0));
        cyc("d2",  v(0, 0, 32'h0,      0, 0,         0, 0, 0,        0, 0, 0));
        cyc("d3",  v(0, 1, 32'hDEAD,   0, 0,         0, 0, 0,        0, 0, 0));
        cyc("d4",  v(0, 0, 32'h0,      0, 0,         0, 1, 32'h3004, 0, 0, 0));
        cyc("d5",  v(0, 1, 32'hB7,     0, 0,         0, 0, 0,        0, 0, 0));
        cyc("d6",  v(0, 0, 32'h0,      0, 0,         0, 1, 32'h3008, 1, 32'h3004, 32'hB7));
        cyc("d7",  v(0, 0, 32'h0,      1, 32'h5000,  0, 0, 0,        0, 0, 0));
        cyc("d8",  v(0, 0, 32'h0,      1, 32'h6000,  0, 0, 0,        0, 0, 0));
        cyc("d9",  v(0, 1, 32'hBEEF,   0, 0,         0, 0, 0,        0, 0, 0));
        cyc("d10", v(0, 0, 32'h0,      0, 0,         0, 1, 32'h6000, 0, 0, 0));

        // Reset in WAIT; a stale response on release must not be taken.
        do_reset("reset3");
        cyc("r0",  v(0, 1, 32'hBAD0,   0, 0, 0, 1, 32'h1000, 0, 0, 0));
        cyc("r1",  v(0, 0, 32'h0,      0, 0, 0, 0, 0,        0, 0, 0));
        cyc("r2",  v(0, 1, 32'hC8,     0, 0, 0, 0, 0,        0, 0, 0));
        cyc("r3",  v(0, 0, 32'h0,      0, 0, 0, 1, 32'h1004, 1, 32'h1000, 32'hC8));

        do_reset("reset4");
        run_random(4000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
